// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: NOP encoding, default reset PC and the
// RUN/HALT state encoding.
package if_stage_pkg;

   localparam logic [31:0] NOP              = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched instruction, holds it on stall,
// or takes a bubble (NOP, valid=0, zero PCs).
module if_id_reg
   import if_stage_pkg::*;
#(
   parameter int n = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         bubble,
   input  logic         load,
   input  logic [n-1:0] instr,
   input  logic [n-1:0] pc,
   input  logic [n-1:0] pc_plus4,
   output logic [n-1:0] id_instr,
   output logic [n-1:0] id_pc,
   output logic [n-1:0] id_pc_plus4,
   output logic         id_valid
);

   localparam logic [n-1:0] nop_word = n'(NOP);

   // NOTE: reset is synchronous, so it is just the highest-priority branch
   // inside the clocked block and is not in the sensitivity list.
   always_ff @(posedge clk) begin
      if (!rst_n || bubble) begin
         // NOTE: state uses non-blocking assignments so every register
         // samples pre-edge values regardless of statement order.
         id_instr    <= nop_word;
         id_pc       <= '0;
         id_pc_plus4 <= '0;
         id_valid    <= 1'b0;
      end else if (load) begin
         id_instr    <= instr;
         id_pc       <= pc;
         id_pc_plus4 <= pc_plus4;
         id_valid    <= 1'b1;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, fetch-fault
// detection with a sticky RUN/HALT FSM, and the IF/ID register.
module if_stage
   import if_stage_pkg::*;
#(
   parameter int           n            = 32,
   parameter logic [n-1:0] RESET_PC     = n'(DEFAULT_RESET_PC),
   parameter int           IMEM_ENTRIES = 265
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         stall_i,
   input  logic         flush_i,
   input  logic         redirect_i,
   input  logic [n-1:0] target_i,
   output logic [n-1:0] imem_addr_o,
   input  logic [n-1:0] imem_rdata_i,
   output logic [n-1:0] id_instr_o,
   output logic [n-1:0] id_pc_o,
   output logic [n-1:0] id_pc_plus4_o,
   output logic         id_valid_o,
   output logic         fault_o
);

   localparam logic [n-3:0] imem_limit = (n-2)'(IMEM_ENTRIES);

   fetch_state_e state;
   logic [n-1:0] pc;
   logic [n-1:0] pc_plus4;
   logic         misaligned;
   logic         out_of_range;
   logic         fault_det;
   logic         id_bubble;

   assign pc_plus4    = pc + n'(4);
   assign imem_addr_o = pc;

   // NOTE: every always_comb output is assigned on every path so no latch
   // can be inferred.
   always_comb begin
      misaligned   = redirect_i && (target_i[1:0] != 2'b00);
      // A stalled fetch is not consumed, so an out-of-range PC only faults
      // once the stage actually tries to advance past it.
      out_of_range = !stall_i && (pc[n-1:2] >= imem_limit);
      fault_det    = (state == RUN) && (misaligned || out_of_range);
      id_bubble    = (state == HALT) || fault_det || redirect_i || flush_i;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= RUN;
         pc      <= RESET_PC;
         fault_o <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (fault_det) begin
                  state   <= HALT;
                  fault_o <= 1'b1;
               end else if (redirect_i) begin
                  pc <= target_i;
               end else if (!stall_i) begin
                  pc <= pc_plus4;
               end
            end
            HALT: begin
            end
         endcase
      end
   end

   if_id_reg #(
      .n(n)
   ) u_if_id_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .bubble     (id_bubble),
      .load       (!stall_i),
      .instr      (imem_rdata_i),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .id_instr   (id_instr_o),
      .id_pc      (id_pc_o),
      .id_pc_plus4(id_pc_plus4_o),
      .id_valid   (id_valid_o)
   );

endmodule
